// File: rtl/mult_div_hilo_unit_if.sv
// Issue/result bus between pipeline control and the multiply/divide HI/LO unit.
// master: pipeline control side (drives issue signals).
// slave : the execution unit (drives status and HI/LO).
interface mult_div_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             iStart;
  logic [4:0]       iOp;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oBusy;
  logic             oDone;
  logic             oDivZero;
  logic [WIDTH-1:0] oHI;
  logic [WIDTH-1:0] oLO;
  logic [WIDTH-1:0] oResult;

  modport master (
    output iStart, iOp, iA, iB,
    input  oBusy, oDone, oDivZero, oHI, oLO, oResult
  );

  modport slave (
    input  iStart, iOp, iA, iB,
    output oBusy, oDone, oDivZero, oHI, oLO, oResult
  );
endinterface

// File: rtl/mult_div_hilo_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO pair.
// MULT/MULTU use radix-2 shift-add; DIV/DIVU use restoring division.
// Both work on magnitudes and fix the sign in a final FIX state.
// Optional build macro: MULDIV_EARLY_OUT_EN. When it is defined, a multiply
// leaves its iteration loop as soon as the remaining multiplier magnitude is
// zero, and the partial product is realigned in FIX.
module mult_div_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic               iCLK,
  input  logic               iRST,
  mult_div_hilo_unit_if.slave bus
);

  // ALU operation codes shared with the ALU control block
  localparam logic [4:0] OPMULT  = 5'h10;
  localparam logic [4:0] OPMULTU = 5'h11;
  localparam logic [4:0] OPDIV   = 5'h12;
  localparam logic [4:0] OPDIVU  = 5'h13;
  localparam logic [4:0] OPMTHI  = 5'h14;
  localparam logic [4:0] OPMTLO  = 5'h15;
  localparam logic [4:0] OPMFHI  = 5'h16;
  localparam logic [4:0] OPMFLO  = 5'h17;

  localparam int                 CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]      CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0]      CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  // Two's complement magnitude when the value is treated as signed
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v,
                                             input logic              sgn);
    return (sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
  endfunction

  // Conditional negation of a single-width result
  function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v,
                                               input logic              neg);
    return neg ? (~v + ONE_W) : v;
  endfunction

  // Conditional negation of a double-width product
  function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] v,
                                                  input logic                neg);
    return neg ? (~v + ONE_2W) : v;
  endfunction

  state_t           state_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
  logic             divz_out_q;

  // Iteration datapath: opb_q holds multiplicand or divisor magnitude,
  // acc_hi_q/acc_lo_q hold partial product or remainder/quotient.
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic             rneg_q;
  logic             is_div_q;
  logic             divz_q;

  logic             op_signed;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             mul_skip;
  logic             mul_last;
  logic [WIDTH:0]   mul_sum_d;
  logic [WIDTH:0]   div_sh_d;
  logic [WIDTH:0]   div_diff_d;
  logic [2*WIDTH-1:0] prod_al_d;
  logic [2*WIDTH-1:0] prod_fix_d;
  logic [WIDTH-1:0] quo_fix_d;
  logic [WIDTH-1:0] rem_fix_d;
  logic [WIDTH-1:0] result_d;

  // Issue-time operand conditioning: magnitudes and result signs
  always_comb begin
    op_signed = (bus.iOp == OPMULT) || (bus.iOp == OPDIV);
    sign_a    = op_signed & bus.iA[WIDTH-1];
    sign_b    = op_signed & bus.iB[WIDTH-1];
    a_mag     = f_mag(bus.iA, op_signed);
    b_mag     = f_mag(bus.iB, op_signed);
`ifdef MULDIV_EARLY_OUT_EN
    mul_skip  = (b_mag == '0);
`else
    mul_skip  = 1'b0;
`endif
  end

  // One iteration step for each algorithm plus the loop exit test
  always_comb begin
    mul_sum_d = {1'b0, acc_hi_q};
    if (mplier_q[0]) begin
      mul_sum_d = mul_sum_d + {1'b0, opb_q};
    end
    div_sh_d   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff_d = div_sh_d - {1'b0, opb_q};
`ifdef MULDIV_EARLY_OUT_EN
    mul_last   = (cnt_q == CNT_MAX) || (mplier_q == '0);
`else
    mul_last   = (cnt_q == CNT_MAX);
`endif
  end

  // Sign correction (and early-exit realignment) applied in FIX
  always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
    prod_al_d = {acc_hi_q, acc_lo_q} >> (CNT_MAX - cnt_q);
`else
    prod_al_d = {acc_hi_q, acc_lo_q};
`endif
    prod_fix_d = f_neg_2w(prod_al_d, neg_q);
    quo_fix_d  = f_neg_w(acc_lo_q, neg_q);
    rem_fix_d  = f_neg_w(acc_hi_q, rneg_q);
  end

  // Control FSM with HI/LO and iteration datapath; reset clears control and HI/LO
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= S_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      divz_out_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      divz_out_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.iStart) begin
            case (bus.iOp)
              OPMULT, OPMULTU: begin
                opb_q    <= a_mag;
                mplier_q <= b_mag;
                acc_hi_q <= '0;
                acc_lo_q <= '0;
                cnt_q    <= '0;
                neg_q    <= sign_a ^ sign_b;
                rneg_q   <= 1'b0;
                is_div_q <= 1'b0;
                divz_q   <= 1'b0;
                busy_q   <= 1'b1;
                state_q  <= mul_skip ? S_FIX : S_MUL;
              end
              OPDIV, OPDIVU: begin
                cnt_q    <= '0;
                is_div_q <= 1'b1;
                busy_q   <= 1'b1;
                if (bus.iB == '0) begin
                  // Divide by zero: commit raw values straight from FIX
                  divz_q   <= 1'b1;
                  acc_hi_q <= bus.iA;
                  acc_lo_q <= '1;
                  state_q  <= S_FIX;
                end else begin
                  divz_q   <= 1'b0;
                  opb_q    <= b_mag;
                  acc_hi_q <= '0;
                  acc_lo_q <= a_mag;
                  neg_q    <= sign_a ^ sign_b;
                  rneg_q   <= sign_a;
                  state_q  <= S_DIV;
                end
              end
              OPMTHI:  hi_q <= bus.iA;
              OPMTLO:  lo_q <= bus.iA;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (mul_last) begin
            state_q <= S_FIX;
          end else begin
            acc_hi_q <= mul_sum_d[WIDTH:1];
            acc_lo_q <= {mul_sum_d[0], acc_lo_q[WIDTH-1:1]};
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_ONE;
          end
        end
        S_DIV: begin
          if (cnt_q == CNT_MAX) begin
            state_q <= S_FIX;
          end else begin
            if (!div_diff_d[WIDTH]) begin
              acc_hi_q <= div_diff_d[WIDTH-1:0];
              acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi_q <= div_sh_d[WIDTH-1:0];
              acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_FIX: begin
          if (divz_q) begin
            hi_q <= acc_hi_q;
            lo_q <= acc_lo_q;
          end else if (is_div_q) begin
            hi_q <= rem_fix_d;
            lo_q <= quo_fix_d;
          end else begin
            {hi_q, lo_q} <= prod_fix_d;
          end
          done_q     <= 1'b1;
          divz_out_q <= divz_q;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Move-from-HI/LO read port; other op codes read as zero
  always_comb begin
    result_d = '0;
    case (bus.iOp)
      OPMFHI:  result_d = hi_q;
      OPMFLO:  result_d = lo_q;
      default: result_d = '0;
    endcase
  end

  assign bus.oBusy    = busy_q;
  assign bus.oDone    = done_q;
  assign bus.oDivZero = divz_out_q;
  assign bus.oHI      = hi_q;
  assign bus.oLO      = lo_q;
  assign bus.oResult  = result_d;

endmodule

// File: tb/tb_mult_div_hilo_unit.sv
// Scoreboard bench for mult_div_hilo_unit: stimulus pushes expected commits,
// a monitor pops and compares on every oDone. Reference results come from
// plain 64-bit arithmetic. Honours MULDIV_EARLY_OUT_EN for expected latency.
module tb_mult_div_hilo_unit;

  localparam logic [4:0] OPMULT  = 5'h10;
  localparam logic [4:0] OPMULTU = 5'h11;
  localparam logic [4:0] OPDIV   = 5'h12;
  localparam logic [4:0] OPDIVU  = 5'h13;
  localparam logic [4:0] OPMTHI  = 5'h14;
  localparam logic [4:0] OPMTLO  = 5'h15;
  localparam logic [4:0] OPMFHI  = 5'h16;
  localparam logic [4:0] OPMFLO  = 5'h17;
  localparam logic [4:0] OPBAD   = 5'h03;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          icyc;
  } exp_t;

  logic iCLK = 1'b0;
  logic iRST;
  always #5 iCLK = ~iCLK;

  mult_div_hilo_unit_if #(.WIDTH(32)) bus ();

  mult_div_hilo_unit #(.WIDTH(32)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  exp_t        sb[$];
  exp_t        mon_e;
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [4:0]  op_tab[9];

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every committed MULT/DIV is matched against the oldest expectation
  always @(negedge iCLK) begin
    if (iRST === 1'b0) begin
      if (bus.oDone === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("done_hi", {32'd0, bus.oHI}, {32'd0, mon_e.hi});
          check("done_lo", {32'd0, bus.oLO}, {32'd0, mon_e.lo});
          check("done_divzero", {63'd0, bus.oDivZero}, {63'd0, mon_e.dz});
          check("done_latency", 64'(cyc - mon_e.icyc - 1), 64'(mon_e.lat));
        end
      end else if (bus.oDivZero === 1'b1) begin
        check("divzero_without_done", 64'd1, 64'd0);
      end
    end
  end

  // Expected issue-to-commit edge count
  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] b);
    logic [31:0] mag;
    int          k;
    if (op == OPDIV || op == OPDIVU) return (b == 32'd0) ? 1 : 34;
`ifdef MULDIV_EARLY_OUT_EN
    mag = (op == OPMULT && b[31]) ? (32'd0 - b) : b;
    if (mag == 32'd0) return 1;
    k = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
    return k + 2;
`else
    mag = b;
    k   = 0;
    return 34 + k + int'(mag[0] & 1'b0);
`endif
  endfunction

  // Reference model for MULT/DIV: push expectation, advance architectural HI/LO
  task automatic model_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sp, sa, sbv, q, r;
    logic [63:0] up;
    e.dz = 1'b0;
    case (op)
      OPMULT: begin
        sp   = longint'($signed(a)) * longint'($signed(b));
        e.hi = sp[63:32];
        e.lo = sp[31:0];
      end
      OPMULTU: begin
        up   = {32'd0, a} * {32'd0, b};
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
          e.dz = 1'b1;
        end else if (op == OPDIV) begin
          sa   = longint'($signed(a));
          sbv  = longint'($signed(b));
          q    = sa / sbv;
          r    = sa % sbv;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    e.lat  = exp_lat(op, b);
    e.icyc = cyc;
    sb.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  // Wait (bounded) until the unit is idle; call at a negedge
  task automatic wait_idle();
    int n = 0;
    while (bus.oBusy !== 1'b0 && n < 200) begin
      @(negedge iCLK);
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'd1, 64'd0);
  endtask

  // Issue one op at a negedge; returns at the following negedge
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bit muldiv;
    wait_idle();
    muldiv     = (op == OPMULT || op == OPMULTU || op == OPDIV || op == OPDIVU);
    bus.iStart = 1'b1;
    bus.iOp    = op;
    bus.iA     = a;
    bus.iB     = b;
    if (muldiv) model_op(op, a, b);
    #1;
    if (op == OPMFHI) check("mfhi_result", {32'd0, bus.oResult}, {32'd0, m_hi});
    if (op == OPMFLO) check("mflo_result", {32'd0, bus.oResult}, {32'd0, m_lo});
    if (op == OPMTHI) m_hi = a;
    if (op == OPMTLO) m_lo = a;
    @(negedge iCLK);
    bus.iStart = 1'b0;
    bus.iOp    = OPBAD;
    if (!muldiv) begin
      check("hi_after_op", {32'd0, bus.oHI}, {32'd0, m_hi});
      check("lo_after_op", {32'd0, bus.oLO}, {32'd0, m_lo});
      check("busy_after_op", {63'd0, bus.oBusy}, 64'd0);
    end
  endtask

  // Count busy cycles after an issue (bounded)
  task automatic count_busy(output int bc);
    bc = 0;
    while (bus.oBusy === 1'b1 && bc < 200) begin
      bc++;
      @(negedge iCLK);
    end
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          bc;
    logic [31:0] hi_pre;
    logic [4:0]  op;
    op_tab = '{OPMULT, OPMULTU, OPDIV, OPDIVU, OPMTHI, OPMTLO, OPMFHI, OPMFLO, OPBAD};
    iRST       = 1'b1;
    bus.iStart = 1'b0;
    bus.iOp    = OPBAD;
    bus.iA     = '0;
    bus.iB     = '0;
    m_hi       = '0;
    m_lo       = '0;
    repeat (3) @(negedge iCLK);
    check("reset_hi", {32'd0, bus.oHI}, 64'd0);
    check("reset_lo", {32'd0, bus.oLO}, 64'd0);
    check("reset_busy", {63'd0, bus.oBusy}, 64'd0);
    check("reset_done", {63'd0, bus.oDone}, 64'd0);
    check("reset_divzero", {63'd0, bus.oDivZero}, 64'd0);
    iRST = 1'b0;
    @(negedge iCLK);

    // Directed cases with known results
    issue(OPMULT, 32'hFFFF_FFFE, 32'd3);
    count_busy(bc);
    check("mult_busy_cycles", 64'(bc), 64'(exp_lat(OPMULT, 32'd3)));
    check("mult_hi", {32'd0, bus.oHI}, 64'hFFFF_FFFF);
    check("mult_lo", {32'd0, bus.oLO}, 64'hFFFF_FFFA);

    issue(OPMULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    count_busy(bc);
    check("multu_busy_cycles", 64'(bc), 64'd34);
    check("multu_hi", {32'd0, bus.oHI}, 64'hFFFF_FFFE);
    check("multu_lo", {32'd0, bus.oLO}, 64'h0000_0001);

    issue(OPDIV, 32'hFFFF_FFF9, 32'd2);
    count_busy(bc);
    check("div_busy_cycles", 64'(bc), 64'd34);
    check("div_lo", {32'd0, bus.oLO}, 64'hFFFF_FFFD);
    check("div_hi", {32'd0, bus.oHI}, 64'hFFFF_FFFF);

    issue(OPDIVU, 32'd100, 32'd0);
    count_busy(bc);
    check("divz_busy_cycles", 64'(bc), 64'd1);
    check("divz_lo", {32'd0, bus.oLO}, 64'hFFFF_FFFF);
    check("divz_hi", {32'd0, bus.oHI}, 64'd100);

    issue(OPDIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(bc);
    check("div_ovf_lo", {32'd0, bus.oLO}, 64'h8000_0000);
    check("div_ovf_hi", {32'd0, bus.oHI}, 64'd0);

    issue(OPMULTU, 32'd5, 32'd1);
    count_busy(bc);
`ifdef MULDIV_EARLY_OUT_EN
    check("multu_early_busy", 64'(bc), 64'd3);
`else
    check("multu_full_busy", 64'(bc), 64'd34);
`endif
    check("multu5_lo", {32'd0, bus.oLO}, 64'd5);
    check("multu5_hi", {32'd0, bus.oHI}, 64'd0);

    // Moves on consecutive edges, then reads
    issue(OPMTHI, 32'h0000_1234, 32'd0);
    issue(OPMTLO, 32'h0000_5678, 32'd0);
    check("mthi_value", {32'd0, bus.oHI}, 64'h1234);
    check("mtlo_value", {32'd0, bus.oLO}, 64'h5678);
    issue(OPMFHI, 32'd0, 32'd0);
    issue(OPMFLO, 32'd0, 32'd0);

    // Issue while busy is ignored; reset mid-operation aborts
    hi_pre = m_hi;
    issue(OPMULT, 32'd7, 32'd9);
    repeat (9) @(negedge iCLK);
    bus.iStart = 1'b1;
    bus.iOp    = OPMTHI;
    bus.iA     = 32'hDEAD_BEEF;
    @(negedge iCLK);
    bus.iStart = 1'b0;
    check("busy_issue_ignored_hi", {32'd0, bus.oHI}, {32'd0, hi_pre});
    check("busy_still_high", {63'd0, bus.oBusy}, 64'd1);
    iRST = 1'b1;
    @(negedge iCLK);
    check("midop_reset_hi", {32'd0, bus.oHI}, 64'd0);
    check("midop_reset_lo", {32'd0, bus.oLO}, 64'd0);
    check("midop_reset_busy", {63'd0, bus.oBusy}, 64'd0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    iRST = 1'b0;
    repeat (2) @(negedge iCLK);
    check("midop_no_done", {63'd0, bus.oDone}, 64'd0);

    // Randomized mix, issued back-to-back as soon as the unit is idle
    for (int i = 0; i < 60; i++) begin
      op = op_tab[$urandom_range(0, 8)];
      issue(op, rnd_opnd(), rnd_opnd());
    end
    wait_idle();
    repeat (2) @(negedge iCLK);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
